// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store type codes, FSM state encoding and byte-enable constants for mem_stage_lsu
package lsu_pkg;

    localparam logic [2:0] LT_LB   = 3'b000;
    localparam logic [2:0] LT_LH   = 3'b001;
    localparam logic [2:0] LT_LW   = 3'b010;
    localparam logic [2:0] LT_LBU  = 3'b100;
    localparam logic [2:0] LT_LHU  = 3'b101;
    localparam logic [2:0] LT_NONE = 3'b111;

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - request/ready data-memory bus between the MEM stage and data memory
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - selects byte/half of the read word and sign- or zero-extends it
import lsu_pkg::*;

module lsu_load_format (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane, then extend according to the load type
    always_comb begin
        byte_sel = rdata_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = rdata_i;
        case (load_type_i)
            LT_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            LT_LBU:  result_o = {24'd0, byte_sel};
            LT_LHU:  result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - rv32i MEM stage load/store unit; optional MEM_ALIGN_CHECK_EN adds misaligned-access rejection
import lsu_pkg::*;

module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             mem_result,
    input  logic [31:0]             mem_op2_selected,
    input  logic                    mem_memory_write,
    input  logic [2:0]              mem_memory_load_type,
    input  logic [1:0]              mem_memory_store_type,
    input  logic                    mem_wb_load,
    input  logic                    mem_wb_reg_file,
    input  logic [4:0]              mem_wb_rd,
    mem_stage_lsu_if.master         dmem,
    output logic                    mem_stall,
    output logic [31:0]             wb_result,
    output logic                    wb_reg_file,
    output logic [4:0]              wb_rd,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                    misaligned,
`endif
    output logic                    bus_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, isld_q, isld_d, bus_err_q, bus_err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  lt_q, lt_d;
    logic [1:0]  off_q, off_d;

    logic        is_load, is_store, mem_op, mis_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, fmt_c;

    assign is_load  = (mem_memory_load_type != LT_NONE) && mem_wb_load;
    assign is_store = mem_memory_write && (mem_memory_store_type != ST_NONE);
    assign mem_op   = is_load || is_store;

    // byte lanes and replicated store data for the access being issued
    always_comb begin
        be_c    = BE_WORD;
        wdata_c = mem_op2_selected;
        if (is_store) begin
            case (mem_memory_store_type)
                ST_SB: begin
                    be_c    = BE_BYTE << mem_result[1:0];
                    wdata_c = {4{mem_op2_selected[7:0]}};
                end
                ST_SH: begin
                    be_c    = BE_HALF << {mem_result[1], 1'b0};
                    wdata_c = {2{mem_op2_selected[15:0]}};
                end
                default: begin
                    be_c    = BE_WORD;
                    wdata_c = mem_op2_selected;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic half_op, word_op;
    // halfword/word accesses must be naturally aligned; stores take precedence over loads
    always_comb begin
        half_op = is_store ? (mem_memory_store_type == ST_SH)
                           : ((mem_memory_load_type == LT_LH) || (mem_memory_load_type == LT_LHU));
        word_op = is_store ? (mem_memory_store_type == ST_SW)
                           : (mem_memory_load_type == LT_LW);
        mis_c   = (state_q == S_IDLE) && mem_op &&
                  ((half_op && mem_result[0]) || (word_op && (mem_result[1:0] != 2'b00)));
    end
    assign misaligned = mis_c;
`else
    assign mis_c = 1'b0;
`endif

    lsu_load_format u_fmt (
        .rdata_i     (dmem.dmem_rdata),
        .offset_i    (off_q),
        .load_type_i (lt_q),
        .result_o    (fmt_c)
    );

    // state and bus registers; reset drops any outstanding request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            isld_q    <= 1'b0;
            bus_err_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            load_q    <= '0;
            be_q      <= '0;
            lt_q      <= LT_NONE;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            isld_q    <= isld_d;
            bus_err_q <= bus_err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
            be_q      <= be_d;
            lt_q      <= lt_d;
            off_q     <= off_d;
        end
    end

    // next-state logic: issue in IDLE, hold the bus in WAIT, hand back one result in RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        isld_d    = isld_q;
        bus_err_d = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        be_d      = be_q;
        lt_d      = lt_q;
        off_d     = off_q;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !mis_c) begin
                    mem_stall = 1'b1;
                    state_d   = S_WAIT;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    isld_d    = !is_store;
                    addr_d    = {mem_result[31:2], 2'b00};
                    wdata_d   = wdata_c;
                    be_d      = be_c;
                    lt_d      = mem_memory_load_type;
                    off_d     = mem_result[1:0];
                    cnt_d     = '0;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (dmem.dmem_ready) begin
                    if (isld_q) load_d = fmt_c;
                    req_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    load_d    = '0;
                    req_d     = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign wb_result   = ((state_q == S_RESP) && isld_q) ? load_q : mem_result;
    assign wb_reg_file = mem_wb_reg_file && !mis_c;
    assign wb_rd       = mem_wb_rd;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_result;
    logic [31:0] mem_op2_selected;
    logic        mem_memory_write;
    logic [2:0]  mem_memory_load_type;
    logic [1:0]  mem_memory_store_type;
    logic        mem_wb_load;
    logic        mem_wb_reg_file;
    logic [4:0]  mem_wb_rd;
    logic        mem_stall;
    logic [31:0] wb_result;
    logic        wb_reg_file;
    logic [4:0]  wb_rd;
    logic        bus_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_result            (mem_result),
        .mem_op2_selected      (mem_op2_selected),
        .mem_memory_write      (mem_memory_write),
        .mem_memory_load_type  (mem_memory_load_type),
        .mem_memory_store_type (mem_memory_store_type),
        .mem_wb_load           (mem_wb_load),
        .mem_wb_reg_file       (mem_wb_reg_file),
        .mem_wb_rd             (mem_wb_rd),
        .dmem                  (bus),
        .mem_stall             (mem_stall),
        .wb_result             (wb_result),
        .wb_reg_file           (wb_reg_file),
        .wb_rd                 (wb_rd),
`ifdef MEM_ALIGN_CHECK_EN
        .misaligned            (misaligned),
`endif
        .bus_err               (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          st_cycles, rq_cycles, berr_cnt, done;
    logic        addr_stable, saw_we;
    logic [31:0] wbres, saw_addr, saw_wdata;
    logic [3:0]  saw_be;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        mem_result            = 32'h0;
        mem_op2_selected      = 32'h0;
        mem_memory_write      = 1'b0;
        mem_memory_load_type  = 3'b111;
        mem_memory_store_type = 2'b11;
        mem_wb_load           = 1'b0;
        mem_wb_reg_file       = 1'b0;
        mem_wb_rd             = 5'd0;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [2:0] lt);
        set_idle();
        mem_result           = a;
        mem_memory_load_type = lt;
        mem_wb_load          = 1'b1;
        mem_wb_reg_file      = 1'b1;
        mem_wb_rd            = 5'd7;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
        set_idle();
        mem_result            = a;
        mem_op2_selected      = d;
        mem_memory_write      = 1'b1;
        mem_memory_store_type = st;
    endtask

    // called at posedge+1 with inputs applied; returns in the first cycle with mem_stall low
    task automatic run_op(input int rdy_delay, input logic [31:0] rdata);
        int wait_n;
        st_cycles = 0; rq_cycles = 0; berr_cnt = 0; done = 0; wait_n = 0;
        addr_stable = 1'b1;
        for (int n = 0; n < 40 && done == 0; n++) begin
            #1;
            if (bus.dmem_req) begin
                if (rq_cycles == 0) begin
                    saw_addr = bus.dmem_addr; saw_be = bus.dmem_be;
                    saw_wdata = bus.dmem_wdata; saw_we = bus.dmem_we;
                end else if (bus.dmem_addr !== saw_addr || bus.dmem_be !== saw_be ||
                             bus.dmem_wdata !== saw_wdata || bus.dmem_we !== saw_we) begin
                    addr_stable = 1'b0;
                end
                rq_cycles++;
                if (wait_n == rdy_delay) begin
                    bus.dmem_ready = 1'b1;
                    bus.dmem_rdata = rdata;
                end
                wait_n++;
            end
            if (bus_err) berr_cnt++;
            if (mem_stall) st_cycles++;
            else begin
                wbres = wb_result;
                done  = 1;
            end
            if (done == 0) begin
                @(posedge clk);
                #1;
                bus.dmem_ready = 1'b0;
            end
        end
        chk("op_completes", 32'(done), 32'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        set_idle();
        mem_result = 32'h11111111;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req",    32'(bus.dmem_req), 32'd0);
        chk("rst_we",     32'(bus.dmem_we),  32'd0);
        chk("rst_be",     32'(bus.dmem_be),  32'd0);
        chk("rst_addr",   bus.dmem_addr,     32'h0);
        chk("rst_wdata",  bus.dmem_wdata,    32'h0);
        chk("rst_stall",  32'(mem_stall),    32'd0);
        chk("rst_wb",     wb_result,         32'h11111111);
        chk("rst_buserr", 32'(bus_err),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // non-memory op passes straight through
        set_idle();
        mem_result = 32'hDEADBEEF; mem_wb_reg_file = 1'b1; mem_wb_rd = 5'd5;
        #1;
        chk("pass_wb",    wb_result,           32'hDEADBEEF);
        chk("pass_stall", 32'(mem_stall),      32'd0);
        chk("pass_rf",    32'(wb_reg_file),    32'd1);
        chk("pass_rd",    32'(wb_rd),          32'd5);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("pass_noreq", 32'(bus.dmem_req), 32'd0);
        end

        // SB at 0x1003
        next_cycle();
        set_store(32'h00001003, 32'h12345678, 2'b00);
        run_op(0, 32'h0);
        chk("sb_addr",  saw_addr,          32'h00001000);
        chk("sb_be",    32'(saw_be),       32'h8);
        chk("sb_wdata", saw_wdata,         32'h78787878);
        chk("sb_we",    32'(saw_we),       32'd1);
        chk("sb_stall", 32'(st_cycles),    32'd2);
        chk("sb_wb",    wbres,             32'h00001003);
        next_cycle(); set_idle();

        // SH at 0x2002
        next_cycle();
        set_store(32'h00002002, 32'h0000BEEF, 2'b01);
        run_op(0, 32'h0);
        chk("sh_be",    32'(saw_be),       32'hC);
        chk("sh_wdata", saw_wdata,         32'hBEEFBEEF);
        next_cycle(); set_idle();

        // SW at 0x3000
        next_cycle();
        set_store(32'h00003000, 32'hA5A5C3C3, 2'b10);
        run_op(0, 32'h0);
        chk("sw_be",    32'(saw_be),       32'hF);
        chk("sw_wdata", saw_wdata,         32'hA5A5C3C3);
        next_cycle(); set_idle();

        // LB at 0x1001
        next_cycle();
        set_load(32'h00001001, 3'b000);
        run_op(0, 32'h80FF7F01);
        chk("lb_wb",    wbres,             32'h0000007F);
        chk("lb_we",    32'(saw_we),       32'd0);
        chk("lb_be",    32'(saw_be),       32'hF);
        next_cycle(); set_idle();

        // LH at 0x1002
        next_cycle();
        set_load(32'h00001002, 3'b001);
        run_op(0, 32'h8001AAAA);
        chk("lh_wb",    wbres,             32'hFFFF8001);
        chk("lh_addr",  saw_addr,          32'h00001000);
        next_cycle(); set_idle();

        // LHU at 0x1002
        next_cycle();
        set_load(32'h00001002, 3'b101);
        run_op(0, 32'h8001AAAA);
        chk("lhu_wb",   wbres,             32'h00008001);
        next_cycle(); set_idle();

        // LBU at 0x1003
        next_cycle();
        set_load(32'h00001003, 3'b100);
        run_op(0, 32'h80FF7F01);
        chk("lbu_wb",   wbres,             32'h00000080);
        next_cycle(); set_idle();

        // LW with ready delayed 3 cycles
        next_cycle();
        set_load(32'h00004000, 3'b010);
        run_op(3, 32'hCAFEF00D);
        chk("lw_req",    32'(rq_cycles),   32'd4);
        chk("lw_stall",  32'(st_cycles),   32'd5);
        chk("lw_stable", 32'(addr_stable), 32'd1);
        chk("lw_wb",     wbres,            32'hCAFEF00D);
        next_cycle(); set_idle();

        // timeout: no ready ever
        next_cycle();
        set_load(32'h00005000, 3'b010);
        run_op(99, 32'h0);
        chk("to_wb",     wbres,            32'h0);
        chk("to_berr",   32'(berr_cnt),    32'd1);
        chk("to_stall",  32'(st_cycles),   32'd5);
        next_cycle(); set_idle();
        #1;
        chk("to_berr_clr", 32'(bus_err),   32'd0);
        chk("to_idle_req", 32'(bus.dmem_req), 32'd0);
        chk("to_idle_stall", 32'(mem_stall), 32'd0);

        // reset mid-WAIT
        next_cycle();
        set_load(32'h00006000, 3'b010);
        next_cycle();
        next_cycle();
        chk("rw_req_before", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_req_drop",   32'(bus.dmem_req), 32'd0);
        next_cycle();
        chk("rw_req_held",   32'(bus.dmem_req), 32'd0);
        rst = 1'b0;
        set_idle();
        next_cycle();
        set_load(32'h00007000, 3'b010);
        run_op(0, 32'h13579BDF);
        chk("rw_fresh_req",  32'(rq_cycles),   32'd1);
        chk("rw_fresh_addr", saw_addr,         32'h00007000);
        chk("rw_fresh_wb",   wbres,            32'h13579BDF);
        next_cycle(); set_idle();

        repeat (2) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
